// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Bundles the operand and result handshakes of nibble_serial_adder.
//   Parameter WIDTH must match the adder's WIDTH.
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid && ready; the producer holds its payload stable while valid
//   is high and ready is low, and ready never depends on the same channel's
//   payload.
//   Operand channel (master -> slave): in_valid, a, b, cin, sub; slave returns in_ready.
//   Result channel (slave -> master): out_valid, sum, cout, busy [, ovf];
//                                     master returns out_ready.
//   fsm_state : debug view of the adder's controller state (0 IDLE, 1 RUN, 2 DONE).
//   Optional macro NSA_OVERFLOW_EN adds the ovf signal.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic [1:0]       fsm_state;
`ifdef NSA_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy, fsm_state, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy, fsm_state, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy, fsm_state
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy, fsm_state
    );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   WIDTH-bit adder/subtractor that pushes the operands one nibble per clock
//   through a single 4-bit carry-lookahead cell (CLA_4bit), registering the
//   ripple carry between nibbles. Latency is NIB+1 cycles from the accept
//   edge to out_valid; minimum initiation interval is NIB+2 cycles.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : nibble_serial_adder_if.slave (operand/result handshakes, debug state)
//   Parameter WIDTH: multiple of 4, at least 8; must match the interface WIDTH.
//   Optional macro NSA_OVERFLOW_EN: registers a signed-overflow flag on bus.ovf.
module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = $clog2(NIB);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;     // already inverted for subtraction
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [IDXW-1:0]  idx;

    logic [3:0]       cell_sum;
    logic             cell_cout;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;

    // 4-bit carry-lookahead cell: returns {Cout, Sum}.
    function automatic logic [4:0] CLA_4bit(input logic [3:0] A,
                                            input logic [3:0] B,
                                            input logic       Cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = A & B;
        p    = A ^ B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // The only combinational path in the loop: nibble select plus the cell.
    assign {cell_cout, cell_sum} = CLA_4bit(a_reg[{idx, 2'b00} +: 4],
                                            b_reg[{idx, 2'b00} +: 4],
                                            carry_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (idx == LAST) state_next = DONE;
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        // a - b = a + ~b + 1, so cin is overridden by sub
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub | bus.cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 2'b00} +: 4] <= cell_sum;
                    carry_reg                  <= cell_cout;
                    if (idx == LAST) begin
                        cout_reg <= cell_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic ovf_reg;

    // Operand MSBs xor result MSB recovers the carry into the MSB;
    // overflow is that carry xor the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            ovf_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ cell_sum[3] ^ cell_cout;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Directed bench for nibble_serial_adder (WIDTH=32). Inputs are driven and
//   outputs sampled on the falling clock edge. Prints one summary line.
module tb_nibble_serial_adder;
    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [WIDTH:0] exp_q[$];

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one operand set; returns at the falling edge right after the accept edge
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tcin, input logic tsub);
        @(negedge clk);
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tcin;
        bus.sub      = tsub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom();
        bus.b        = $urandom();
        check("run_busy", 64'(bus.busy), 64'd1);
        check("run_in_ready", 64'(bus.in_ready), 64'd0);
    endtask

    // k counts falling edges after the accept edge (k=1 is the first one)
    task automatic wait_valid(output int k);
        k = 1;
        while (!bus.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_handoff_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_handoff_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tcin, input logic tsub,
                          input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int k;
        send(ta, tb_v, tcin, tsub);
        wait_valid(k);
        check({tag, "_latency"}, 64'(k), 64'(NIB + 1));
        check({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
`ifdef NSA_OVERFLOW_EN
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bz) $display("note: %s", tag);
`endif
        handoff();
    endtask

    initial begin
        int          k;
        logic [31:0] sa;
        logic [31:0] sb;
        logic        ssub;
        logic [WIDTH:0] e;

        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_state", 64'(bus.fsm_state), 64'd0);
`ifdef NSA_OVERFLOW_EN
        check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif

        // basic add / subtract
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

        // backpressure: result held for 5 DONE cycles, stray in_valid ignored
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        wait_valid(k);
        check("bp_latency", 64'(k), 64'(NIB + 1));
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", 64'(bus.sum), 64'h2345_678A);
            check("bp_cout", 64'(bus.cout), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            bus.in_valid = 1'b1;
            bus.a        = 32'hDEAD_0000 + 32'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("bp_sum_end", 64'(bus.sum), 64'h2345_678A);
        handoff();

        // reset while RUN at idx=3
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_sum", 64'(bus.sum), 64'd0);
        rst_n = 1'b1;
        run_op("after_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);

        // signed overflow cases
        run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("no_ovf", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

        // in_valid held high with operands changing every cycle; out_ready held high.
        // Accepts land every NIB+2 cycles, results NIB+1 cycles after each accept.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.cin       = 1'b0;
        for (int c = 0; c < 3 * (NIB + 2); c++) begin
            sa   = 32'h0102_0304 + 32'(c) * 32'h1111_1111;
            sb   = 32'hF0E0_D0C0 - 32'(c) * 32'h0101_0101;
            ssub = (c == NIB + 2);
            bus.a   = sa;
            bus.b   = sb;
            bus.sub = ssub;
            check("stream_in_ready", 64'(bus.in_ready), 64'((c % (NIB + 2)) == 0));
            check("stream_out_valid", 64'(bus.out_valid), 64'((c % (NIB + 2)) == NIB + 1));
            if ((c % (NIB + 2)) == 0) begin
                exp_q.push_back({1'b0, sa} + {1'b0, (ssub ? ~sb : sb)} + 33'(ssub));
            end
            if ((c % (NIB + 2)) == NIB + 1) begin
                if (exp_q.size() == 0) begin
                    check("stream_queue", 64'd0, 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_sum", 64'(bus.sum), 64'(e[WIDTH-1:0]));
                    check("stream_cout", 64'(bus.cout), 64'(e[WIDTH]));
                end
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("final_idle", 64'(bus.in_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that sequences wide operands one nibble per cycle through a single 4-bit carry-lookahead cell, `CLA_4bit`. It sits directly around that cell:
- upstream, it feeds the cell A, B and Cin;
- downstream, it consumes Sum and Cout and registers the ripple carry between nibbles.

Operands enter through a valid/ready handshake and the full result leaves through a second one. Area is traded for latency.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8. NIB = WIDTH/4.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ignored when sub=1)
- sub  input  1  1 = compute a - b
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  final carry-out
- busy  output  1  high in RUN or DONE
- ovf  output  1  signed overflow (only with NSA_OVERFLOW_EN)

## Operation
- One clock domain, clk; reset rst_n is asynchronous, active-low.
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready, capture a into a_reg.
  - Capture b into b_reg as b, or ~b when sub=1.
  - Set carry_reg = (sub ? 1 : cin), idx=0, then go to RUN.
- **RUN**
  - The cell is driven with A=a_reg[4*idx+3:4*idx], B=b_reg[4*idx+3:4*idx] and Cin=carry_reg.
  - Each cycle: sum_reg[4*idx+3:4*idx] <= Sum, carry_reg <= Cout, idx <= idx+1.
  - After the edge that processes idx=NIB-1: cout <= Cout, go to DONE.
  - in_ready=0. Inputs are ignored.
- **DONE**
  - out_valid=1. sum, cout and ovf are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- Arithmetic
  - All arithmetic is modulo 2^WIDTH.
  - cout is the true carry of a + b' + c0, where b' = b or ~b and c0 = cin or 1.
  - For subtraction, cout=1 means no borrow (a >= b unsigned).
- idx is a ceil(log2(NIB))-bit counter. It never exceeds NIB-1. There is no wrap-around case.
- Simultaneous events
  - in_valid is sampled only in IDLE.
  - out_ready outside DONE has no effect.
  - Accepting the next operand in the same cycle as the result handoff is not supported. in_ready rises the cycle after the handoff.
- Reset mid-operation (any state)
  - Returns to IDLE immediately.
  - The in-flight operation is discarded. No out_valid is produced for it.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. Internal registers are 0.

## Timing
- Accept edge T0 leads to RUN for edges T0+1 … T0+NIB.
- out_valid is high from the cycle after edge T0+NIB, i.e. NIB+1 cycles after acceptance.
- With out_ready held high, the result handshake completes on the first DONE cycle. in_ready returns one cycle later.
- Minimum initiation interval is NIB+2 cycles: 10 for WIDTH=32.
- sum, cout and ovf are registered outputs. The only combinational logic in the loop is the 4-bit cell plus the nibble select mux.
- A stalled consumer (out_ready=0) holds DONE indefinitely with outputs unchanged.

## Configuration
- Macro: NSA_OVERFLOW_EN.
- **Defined**
  - ovf port exists.
  - At the final RUN edge, ovf <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ Sum[3] ^ Cout. This is carry-into-MSB xor carry-out.
  - ovf is held with sum and reset to 0.
- **Undefined**
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, out_valid exactly 9 cycles after the accept edge.
- a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0. Then a=0x7, b=0x5, sub=1 -> sum=0x00000002, cout=1.
- Backpressure: a=0x12345678, b=0x11111111, cin=1, out_ready=0 for 5 DONE cycles -> sum=0x2345678A held stable, in_ready=0 throughout. in_ready=1 one cycle after the out_ready handshake.
- Reset mid-operation: assert rst_n=0 at RUN idx=3 -> next cycle in_ready=1, out_valid=0, busy=0, sum=0. A new add 0x10+0x20 then completes with sum=0x30.
- NSA_OVERFLOW_EN: 0x7FFFFFFF+0x00000001 -> ovf=1, cout=0. 0x80000000-0x00000001 -> ovf=1, sum=0x7FFFFFFF. 0x00000003+0x00000004 -> ovf=0.
- in_valid held high continuously with changing a/b -> only the values present on accept edges are used; back-to-back results are spaced 10 cycles apart.
